// File: rtl/addr_bus_to_xlink_pkg.sv
// Shared XLink token values and initiator state encoding.
// Common to both bridge directions; imported by the initiator RTL.
package addr_bus_to_xlink_pkg;

    localparam logic [7:0] CT_END   = 8'h01;
    localparam logic [7:0] CT_ACK   = 8'h03;
    localparam logic [7:0] CT_NACK  = 8'h04;
    localparam logic [7:0] CT_WRITE = 8'hC1;
    localparam logic [7:0] CT_READ  = 8'hC2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TX_HDR,
        S_TX_ADDR,
        S_TX_DATA,
        S_TX_END,
        S_WAIT_HDR,
        S_RX_DATA,
        S_WAIT_END,
        S_DONE
    } xfer_state_e;

    function automatic logic [7:0] hdr_tok(input logic wr);
        return wr ? CT_WRITE : CT_READ;
    endfunction

endpackage

// File: rtl/addr_bus_to_xlink_tok_shift32.sv
// 4-byte MSB-first load/shift register with byte counter.
// Ports: load_i/load_word_i load, shift_i/shift_in_i shift, byte_o/word_o/cnt_o view.
module xlink_tok_shift32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] load_word_i,
    input  logic        shift_i,
    input  logic [7:0]  shift_in_i,
    output logic [7:0]  byte_o,
    output logic [31:0] word_o,
    output logic [1:0]  cnt_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    // Load wins over shift so a reload can happen on the last shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else if (load_i) begin
            word_q <= load_word_i;
            cnt_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[23:0], shift_in_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign byte_o = word_q[31:24];
    assign word_o = word_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/addr_bus_to_xlink.sv
// Bus-master-to-XLink initiator: serialises one read/write as a token stream,
// waits for the remote reply, returns data/ack/err. Bus side, TX PHY and RX PHY ports.
module addr_bus_to_xlink
    import addr_bus_to_xlink_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [30:0] addr_bus,
    input  logic [31:0] data_bus_wr,
    output logic [31:0] data_bus_rd,
    input  logic        wr_strobe,
    input  logic        rd_strobe,
    output logic        busy,
    output logic        bus_ack,
    output logic        bus_err,
    output logic        overrun,
    output logic        tx_valid,
    output logic        tx_ctrl,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic        rx_ctrl,
    input  logic [7:0]  rx_data
);

    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    xfer_state_e     state_q, state_d;
    logic            dir_q, dir_d;
    logic            err_q, err_d;
    logic            ovr_q, ovr_d;
    logic [31:0]     data_q, data_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic        sh_load, sh_shift;
    logic [31:0] sh_word, sh_out;
    logic [7:0]  sh_in, sh_byte;
    logic [1:0]  sh_cnt;
    logic        in_wait, to_hit, rx_end;

    // One shifter: address bytes, then write data, then read assembly.
    xlink_tok_shift32 u_shift (
        .clk        (clk),
        .reset      (reset),
        .load_i     (sh_load),
        .load_word_i(sh_word),
        .shift_i    (sh_shift),
        .shift_in_i (sh_in),
        .byte_o     (sh_byte),
        .word_o     (sh_out),
        .cnt_o      (sh_cnt)
    );

    assign in_wait = state_q inside {S_WAIT_HDR, S_RX_DATA, S_WAIT_END};
    assign to_hit  = (TIMEOUT_CYCLES != 0) && in_wait && !rx_valid
                     && (cnt_q == TO_LAST);
    assign rx_end  = rx_valid && rx_ctrl && (rx_data == CT_END);
    assign busy    = (state_q != S_IDLE);
    assign overrun = ovr_q;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        err_d       = err_q;
        data_d      = data_q;
        ovr_d       = 1'b0;
        sh_load     = 1'b0;
        sh_word     = '0;
        sh_shift    = 1'b0;
        sh_in       = '0;
        tx_valid    = 1'b0;
        tx_ctrl     = 1'b0;
        tx_data     = '0;
        bus_ack     = 1'b0;
        bus_err     = 1'b0;
        data_bus_rd = '0;
        cnt_d       = (!in_wait || rx_valid) ? '0 : cnt_q + TO_W'(1);

        if (state_q != S_IDLE) ovr_d = wr_strobe | rd_strobe;
        else                   ovr_d = wr_strobe & rd_strobe;

        unique case (state_q)
            S_IDLE: begin
                if (wr_strobe ^ rd_strobe) begin
                    dir_d   = wr_strobe;
                    data_d  = data_bus_wr;
                    err_d   = 1'b0;
                    sh_load = 1'b1;
                    sh_word = {1'b0, addr_bus};
                    state_d = S_TX_HDR;
                end
            end
            S_TX_HDR: begin
                tx_valid = 1'b1;
                tx_ctrl  = 1'b1;
                tx_data  = hdr_tok(dir_q);
                if (tx_ready) state_d = S_TX_ADDR;
            end
            S_TX_ADDR: begin
                tx_valid = 1'b1;
                tx_data  = sh_byte;
                if (tx_ready) begin
                    sh_shift = 1'b1;
                    if (sh_cnt == 2'd3) begin
                        if (dir_q) begin
                            sh_load = 1'b1;
                            sh_word = data_q;
                            state_d = S_TX_DATA;
                        end else begin
                            state_d = S_TX_END;
                        end
                    end
                end
            end
            S_TX_DATA: begin
                tx_valid = 1'b1;
                tx_data  = sh_byte;
                if (tx_ready) begin
                    sh_shift = 1'b1;
                    if (sh_cnt == 2'd3) state_d = S_TX_END;
                end
            end
            S_TX_END: begin
                tx_valid = 1'b1;
                tx_ctrl  = 1'b1;
                tx_data  = CT_END;
                if (tx_ready) begin
                    // Clear the shifter so read assembly starts from zero.
                    sh_load = 1'b1;
                    state_d = S_WAIT_HDR;
                end
            end
            S_WAIT_HDR: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (rx_valid) begin
                    if (rx_ctrl && rx_data == CT_ACK) begin
                        state_d = dir_q ? S_WAIT_END : S_RX_DATA;
                    end else begin
                        // NACK, stray data or unexpected control.
                        err_d   = 1'b1;
                        state_d = rx_end ? S_DONE : S_WAIT_END;
                    end
                end
            end
            S_RX_DATA: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (rx_valid) begin
                    if (!rx_ctrl) begin
                        sh_shift = 1'b1;
                        sh_in    = rx_data;
                        if (sh_cnt == 2'd3) state_d = S_WAIT_END;
                    end else begin
                        // A premature END already closes the reply.
                        err_d   = 1'b1;
                        state_d = rx_end ? S_DONE : S_WAIT_END;
                    end
                end
            end
            S_WAIT_END: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (rx_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus_ack = 1'b1;
                bus_err = err_q;
                if (!dir_q && !err_q) data_bus_rd = sh_out;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
